// File: rtl/pmod_als_spi_responder.sv
// pmod_als_spi_responder: ADC081S021 (PMOD ALS) SPI read-only responder with a settable light value.
// Define PMOD_ALS_RAMP_EN to auto-increment the held value after every completed frame.
module pmod_als_spi_responder #(
  parameter int SYNC_STAGES = 2,
  parameter int LEAD_ZEROS  = 3,
  parameter int FRAME_BITS  = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sclk_i,
  input  logic       cs_n_i,
  output logic       miso_o,
  input  logic [7:0] sample_i,
  input  logic       sample_we_i,
  output logic       busy_o,
  output logic       frame_done_o,
  output logic       frame_err_o
);
  localparam int CW = $clog2(FRAME_BITS + 1);
  localparam int TZ = FRAME_BITS - LEAD_ZEROS - 8;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t state, state_nx;
  logic [SYNC_STAGES-1:0] sclk_q, cs_q;
  logic sclk_d, cs_d, sclk_s, cs_s, sclk_fall, cs_fall, cs_rise;
  logic [FRAME_BITS-1:0] shreg;
  logic [CW-1:0] bit_cnt;
  logic [7:0] hold_reg;
  logic last_bit;
  assign sclk_s    = sclk_q[SYNC_STAGES-1];
  assign cs_s      = cs_q[SYNC_STAGES-1];
  assign sclk_fall = sclk_d & ~sclk_s;
  assign cs_fall   = cs_d & ~cs_s;
  assign cs_rise   = ~cs_d & cs_s;
  assign last_bit  = bit_cnt == CW'(FRAME_BITS - 1);
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sclk_q <= '1;
      cs_q   <= '1;
      sclk_d <= 1'b1;
      cs_d   <= 1'b1;
    end else begin
      sclk_q <= {sclk_q[SYNC_STAGES-2:0], sclk_i};
      cs_q   <= {cs_q[SYNC_STAGES-2:0], cs_n_i};
      sclk_d <= sclk_s;
      cs_d   <= cs_s;
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else state <= state_nx;
  end
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = cs_fall ? SHIFT : IDLE;
      SHIFT:   state_nx = cs_rise ? IDLE : (sclk_fall && last_bit) ? DONE : SHIFT;
      DONE:    state_nx = cs_rise ? IDLE : DONE;
      default: state_nx = IDLE;
    endcase
  end
  always_comb begin
    miso_o = (state == SHIFT) & shreg[FRAME_BITS-1];
  end
  // CS rise takes priority over a coincident SCLK fall, so a closing frame never shifts.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shreg        <= '0;
      bit_cnt      <= '0;
      busy_o       <= 1'b0;
      frame_done_o <= 1'b0;
      frame_err_o  <= 1'b0;
    end else begin
      frame_done_o <= 1'b0;
      frame_err_o  <= 1'b0;
      if (state == IDLE && cs_fall) begin
        shreg   <= FRAME_BITS'(hold_reg) << TZ;
        bit_cnt <= '0;
        busy_o  <= 1'b1;
      end else if (state == SHIFT && cs_rise) begin
        frame_err_o <= 1'b1;
        busy_o      <= 1'b0;
      end else if (state == SHIFT && sclk_fall) begin
        shreg   <= shreg << 1;
        bit_cnt <= bit_cnt + CW'(1);
      end else if (state == DONE && cs_rise) begin
        frame_done_o <= 1'b1;
        busy_o       <= 1'b0;
      end
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) hold_reg <= 8'h00;
    else if (sample_we_i) hold_reg <= sample_i;
`ifdef PMOD_ALS_RAMP_EN
    else if (state == DONE && cs_rise) hold_reg <= hold_reg + 8'd1;
`endif
  end
endmodule
